instr_fetch_unit: RTL and testbench

IF stage of the pipelined CPU; the initiator side of the instruction-ROM interface. Owns the PC, drives the word address to the combinational instruction ROM, and registers returned words into the IF/ID pipeline register. Handles stall, flush, branch/jump redirect and exception vectoring. Also detects the terminal "j-to-self" spin loop used by test programs.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/if_id_reg.sv | 45 ++++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch constants and the fetch-stage state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_pkg;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;
  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    SPIN = 2'd2
  } fetch_state_t;

  // A j whose 26-bit target equals the word index of its own address
  // is the terminal spin loop that test programs park on.
  function automatic logic is_jump_to_self(input logic [31:0] instr,
                                           input logic [31:0] pc);
    return (instr[31:26] == OP_J) && (instr[25:0] == pc[27:2]);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetched word, its PC and PC+4.
// Latency: 1 cycle from load to outputs.
// Backpressure: holds when neither load nor squash; squash wins over load.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   load, squash        capture inputs / replace contents with a NOP bubble
//   instr_in, pc_in, pc_plus4_in   fetched word and its addresses
//   if_instr, if_pc, if_pc_plus4, if_valid   registered IF/ID contents
module if_id_reg #(
  parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        squash,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid
);
  import cpu_pkg::*;

  // A squashed slot keeps its old PC fields; only instr/valid mark the bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_instr    <= NOP_WORD;
      if_pc       <= 32'h0;
      if_pc_plus4 <= 32'h0;
      if_valid    <= 1'b0;
    end else if (squash) begin
      if_instr    <= NOP_WORD;
      if_valid    <= 1'b0;
    end else if (load) begin
      if_instr    <= instr_in;
      if_pc       <= pc_in;
      if_pc_plus4 <= pc_plus4_in;
      if_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, addresses the combinational ROM, fills IF/ID.
// Latency: rom_addr is pc with no delay; fetched word appears in IF/ID one edge later.
// Backpressure: stall holds pc and IF/ID; exc/irq/redirect always win and squash IF/ID.
//
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   rom_addr / rom_data           word address out, instruction back in the same cycle
//   stall, flush                  hazard-unit hold / squash controls
//   redirect_valid, redirect_pc   taken branch/jump target
//   exc_valid, irq                vector to EXC_VECTOR / IRQ_VECTOR
//   if_instr, if_pc, if_pc_plus4, if_valid   IF/ID register contents
//   spin                          fetch parked on a j-to-self
//   misalign                      sticky flag: a redirect target was not word aligned
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter logic [31:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR,
  parameter logic [31:0] IRQ_VECTOR = cpu_pkg::IRQ_VECTOR,
  parameter logic [31:0] NOP_WORD   = cpu_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_valid,
  input  logic        irq,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        spin,
  output logic        misalign
);
  import cpu_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  logic         misalign_q, misalign_d;
  logic         load, squash;

  assign pc_plus4 = pc_q + 32'd4;
  assign rom_addr = pc_q;
  assign spin     = (state_q == SPIN);
  assign misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    load       = 1'b0;
    squash     = 1'b0;

    case (state_q)
      BOOT: state_d = RUN;
      RUN, SPIN: begin
        if (exc_valid) begin
          pc_d    = EXC_VECTOR;
          squash  = 1'b1;
          state_d = RUN;
        end else if (irq) begin
          pc_d    = IRQ_VECTOR;
          squash  = 1'b1;
          state_d = RUN;
        end else if (redirect_valid) begin
          // Low bits are dropped so rom_addr stays aligned; the fault is only flagged.
          pc_d    = {redirect_pc[31:2], 2'b00};
          squash  = 1'b1;
          state_d = RUN;
          if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
        end else if (state_q == SPIN || stall) begin
          // Parked or stalled: pc and IF/ID hold.
        end else if (flush) begin
          pc_d   = pc_plus4;
          squash = 1'b1;
        end else begin
          load = 1'b1;
          if (is_jump_to_self(rom_data, pc_q)) state_d = SPIN;
          else                                 pc_d    = pc_plus4;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .squash      (squash),
    .instr_in    (rom_data),
    .pc_in       (pc_q),
    .pc_plus4_in (pc_plus4),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .if_valid    (if_valid)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a small test ROM.
// Latency: n/a.
// Backpressure: n/a.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        stall, flush, redirect_valid, exc_valid, irq;
  logic [31:0] redirect_pc;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
  logic        if_valid, spin, misalign;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_valid      (exc_valid),
    .irq            (irq),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_valid       (if_valid),
    .spin           (spin),
    .misalign       (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rom [16];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a[31:6] != 26'h0) return 32'h0;
    return rom[a[5:2]];
  endfunction

  assign rom_data = rom_word(rom_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic        valid;
    logic        spin;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  fetch_state_t m_state;
  logic [31:0]  m_pc, m_instr, m_ipc, m_ipc4;
  logic         m_valid, m_mis;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model for the inputs currently driven, push the expectation,
  // clock the DUT and compare once outputs have settled.
  task automatic cycle();
    exp_t        e;
    logic [31:0] w;
    w = rom_word(m_pc);
    if (!reset) begin
      m_pc = 32'h0; m_state = BOOT; m_instr = 32'h0; m_ipc = 32'h0;
      m_ipc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    end else if (m_state == BOOT) begin
      m_state = RUN;
    end else if (exc_valid || irq || redirect_valid) begin
      if (exc_valid)      m_pc = 32'h8000_0008;
      else if (irq)       m_pc = 32'h8000_0004;
      else begin
        m_pc = {redirect_pc[31:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
      end
      m_instr = 32'h0; m_valid = 1'b0; m_state = RUN;
    end else if (m_state == RUN && !stall) begin
      if (flush) begin
        m_instr = 32'h0; m_valid = 1'b0;
      end else begin
        m_instr = w; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_valid = 1'b1;
        if (w[31:26] == 6'h02 && w[25:0] == m_pc[27:2]) m_state = SPIN;
      end
      if (m_state == RUN) m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.ipc4 = m_ipc4;
    e.valid = m_valid; e.spin = (m_state == SPIN); e.mis = m_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rom_addr", rom_addr, e.pc);
      chk("if_instr", if_instr, e.instr);
      chk("if_valid", {31'h0, if_valid}, {31'h0, e.valid});
      chk("spin", {31'h0, spin}, {31'h0, e.spin});
      chk("misalign", {31'h0, misalign}, {31'h0, e.mis});
      if (e.valid) begin
        chk("if_pc", if_pc, e.ipc);
        chk("if_pc_plus4", if_pc_plus4, e.ipc4);
      end
    end
  endtask

  initial begin
    rom[0]  = 32'h2004_3039; rom[1]  = 32'h0005_3400;
    rom[2]  = 32'h2005_0001; rom[3]  = 32'h00A6_2020;
    rom[4]  = 32'h1085_0001; rom[5]  = 32'h2006_0002;
    rom[6]  = 32'h00C4_4020; rom[7]  = 32'h2007_0003;
    rom[8]  = 32'h00E8_4820; rom[9]  = 32'h2129_0001;
    rom[10] = 32'h0000_0000; rom[11] = 32'h0800_000B;
    for (int i = 12; i < 16; i++) rom[i] = 32'h0;

    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; exc_valid = 1'b0; irq = 1'b0;
    m_state = BOOT; m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    m_ipc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;

    repeat (3) cycle();
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);

    reset = 1'b1;
    cycle();
    chk("boot_valid", {31'h0, if_valid}, 32'h0);
    chk("boot_addr", rom_addr, 32'h0);
    cycle();
    chk("first_instr", if_instr, 32'h2004_3039);
    chk("first_pc", if_pc, 32'h0);
    chk("first_pc4", if_pc_plus4, 32'h4);
    chk("first_addr", rom_addr, 32'h4);

    cycle();
    stall = 1'b1;
    repeat (2) begin
      cycle();
      chk("stall_addr", rom_addr, 32'h8);
      chk("stall_instr", if_instr, 32'h0005_3400);
    end
    stall = 1'b0;
    cycle();
    chk("stall_release", rom_addr, 32'hC);

    cycle();
    chk("at_beq", rom_addr, 32'h10);
    cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h18;
    cycle();
    redirect_valid = 1'b0;
    chk("redir_addr", rom_addr, 32'h18);
    chk("redir_valid", {31'h0, if_valid}, 32'h0);
    cycle();
    chk("redir_instr", if_instr, 32'h00C4_4020);
    chk("redir_ipc", if_pc, 32'h18);

    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_valid", {31'h0, if_valid}, 32'h0);
    chk("flush_addr", rom_addr, 32'h20);

    for (int i = 0; i < 20 && !spin; i++) cycle();
    chk("spin_reached", {31'h0, spin}, 32'h1);
    chk("spin_addr", rom_addr, 32'h2C);
    chk("spin_instr", if_instr, 32'h0800_000B);

    stall = 1'b1; cycle(); stall = 1'b0;
    flush = 1'b1; cycle(); flush = 1'b0;
    chk("spin_hold", {31'h0, spin}, 32'h1);

    exc_valid = 1'b1; cycle(); exc_valid = 1'b0;
    chk("exc_addr", rom_addr, 32'h8000_0008);
    chk("exc_spin", {31'h0, spin}, 32'h0);

    redirect_valid = 1'b1; redirect_pc = 32'h1A;
    cycle();
    redirect_valid = 1'b0;
    chk("mis_addr", rom_addr, 32'h18);
    chk("mis_set", {31'h0, misalign}, 32'h1);
    repeat (10) cycle();
    chk("mis_sticky", {31'h0, misalign}, 32'h1);

    irq = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    cycle();
    irq = 1'b0; redirect_valid = 1'b0;
    chk("irq_addr", rom_addr, 32'h8000_0004);

    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("wrap_addr", rom_addr, 32'h0);
    chk("wrap_ipc4", if_pc_plus4, 32'h0);

    redirect_valid = 1'b1; redirect_pc = 32'h2C;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("spin2", {31'h0, spin}, 32'h1);

    stall = 1'b1; reset = 1'b0;
    cycle();
    chk("midrst_addr", rom_addr, 32'h0);
    chk("midrst_spin", {31'h0, spin}, 32'h0);
    chk("midrst_valid", {31'h0, if_valid}, 32'h0);
    stall = 1'b0; reset = 1'b1;
    cycle();
    cycle();
    chk("restart_instr", if_instr, 32'h2004_3039);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
